otter_int_ctrl: RTL and testbench

- Interrupt controller that drives the trap-entry and trap-return strobes into the OTTER machine-mode CSR block, which consumes intTaken and intRet.
- Synchronizes NUM_IRQ asynchronous external request lines and edge-detects them into sticky pending bits.
- Arbitrates by fixed priority and fires the take strobe only at an instruction boundary, when global and per-source enables allow it.
- Tracks the handler-active state until mret.

---
 rtl/otter_int_pkg.sv | 16 +
 rtl/otter_irq_sync.sv | 40 ++++
 rtl/otter_int_ctrl.sv | 131 +++++++++++++
 tb/tb_otter_int_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_int_pkg.sv
// -----------------------------------------------------------------------------
// otter_int_pkg
//   Shared types and limits for the OTTER interrupt controller.
//   - int_state_t : controller state (IDLE, HANDLER)
//   - MAX_IRQ     : largest supported number of external sources
// -----------------------------------------------------------------------------
package otter_int_pkg;

    localparam int MAX_IRQ = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        HANDLER = 1'b1
    } int_state_t;

endpackage : otter_int_pkg

// File: rtl/otter_irq_sync.sv
// -----------------------------------------------------------------------------
// otter_irq_sync
//   Single-line synchronizer followed by a history flop. Emits a one-cycle
//   rise pulse when the synchronized level goes from 0 to 1.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  synchronous active-low reset (clears chain and history)
//   irq_in  in  asynchronous level request
//   rise    out synchronized rising-edge pulse (sync_out & ~hist)
// -----------------------------------------------------------------------------
module otter_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // NOTE: sequential state uses non-blocking assignments so every flop in the
    // chain samples the value from before the edge; blocking would collapse it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // History is cleared by reset, so a line held high through reset is seen
    // as a fresh rising edge once the chain refills.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : otter_irq_sync

// File: rtl/otter_int_ctrl.sv
// -----------------------------------------------------------------------------
// otter_int_ctrl
//   Interrupt controller feeding the trap-entry / trap-return strobes of the
//   OTTER machine-mode CSR block. External requests are synchronized and
//   edge-detected into sticky pending bits, arbitrated by fixed priority
//   (lowest index wins) and taken only at an instruction boundary when the
//   global and per-source enables allow it. No nesting: while a handler runs
//   further takes are blocked until mret.
//
// Ports:
//   clk             in  system clock
//   rst_n           in  synchronous active-low reset
//   irq_in          in  asynchronous level requests, rising edge = event
//   irq_en          in  per-source enable
//   mie             in  global interrupt enable (CSR)
//   mstatus         in  interrupt-allowed bit (CSR)
//   instr_boundary  in  last cycle of an instruction, next_pc valid
//   mret            in  core executing mret this cycle
//   ovr_clr         in  clears matching overrun bits
//   int_taken       out trap-entry strobe (combinational, to CSR intTaken)
//   int_ret         out trap-return strobe (combinational, to CSR intRet)
//   int_id          out index of the source being / last serviced
//   pending         out pending bits (registered)
//   overrun         out sticky: edge arrived while source already pending
//   in_handler      out controller is in HANDLER (registered)
// -----------------------------------------------------------------------------
module otter_int_ctrl
    import otter_int_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               mie,
    input  logic               mstatus,
    input  logic               instr_boundary,
    input  logic               mret,
    input  logic [NUM_IRQ-1:0] ovr_clr,
    output logic               int_taken,
    output logic               int_ret,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overrun,
    output logic               in_handler
);

    int_state_t         state;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic [ID_W-1:0]    winner;
    logic               take;
    logic [NUM_IRQ-1:0] take_mask;
    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] overrun_nxt;

    // ---------------------------------------------------------------- inputs
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        otter_irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .irq_in(irq_in[g]),
            .rise  (rise[g])
        );
    end

    // ----------------------------------------------------------- arbitration
    assign elig = pending & irq_en;

    // NOTE: winner is given a default before the loop so every path assigns
    // it; otherwise the tool would infer a latch to hold the old value.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) winner = ID_W'(i);
        end
    end

    // mret has priority over a take in IDLE, so the two strobes never overlap.
    // Both strobes are held low while reset is asserted.
    assign take      = rst_n & (state == IDLE) & instr_boundary & mie & mstatus
                     & (|elig) & ~mret;
    assign int_taken = take;
    assign int_ret   = rst_n & mret;

    assign take_mask = take ? (NUM_IRQ'(1) << winner) : '0;

    // A rise on the bit being taken re-arms it (set wins) and is not an
    // overrun, since the earlier request is being serviced this cycle.
    assign pending_nxt = (pending & ~take_mask) | rise;
    assign overrun_nxt = (overrun & ~ovr_clr) | (rise & pending & ~take_mask);

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_handler <= 1'b0;
            int_id     <= '0;
            pending    <= '0;
            overrun    <= '0;
        end else begin
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            case (state)
                IDLE: begin
                    if (take) begin
                        state      <= HANDLER;
                        in_handler <= 1'b1;
                        int_id     <= winner;
                    end
                end
                HANDLER: begin
                    if (mret) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule : otter_int_ctrl

// File: tb/tb_otter_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_otter_int_ctrl
//   Directed self-checking bench for otter_int_ctrl (NUM_IRQ=4, SYNC_STAGES=2).
//   Inputs change 1 time unit after a rising edge; registered outputs are read
//   then, combinational strobes 1 unit after the input change.
// -----------------------------------------------------------------------------
module tb_otter_int_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] irq_en;
    logic       mie;
    logic       mstatus;
    logic       instr_boundary;
    logic       mret;
    logic [3:0] ovr_clr;
    logic       int_taken;
    logic       int_ret;
    logic [1:0] int_id;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       in_handler;

    int errors = 0;
    int checks = 0;

    otter_int_ctrl #(
        .NUM_IRQ    (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_in        (irq_in),
        .irq_en        (irq_en),
        .mie           (mie),
        .mstatus       (mstatus),
        .instr_boundary(instr_boundary),
        .mret          (mret),
        .ovr_clr       (ovr_clr),
        .int_taken     (int_taken),
        .int_ret       (int_ret),
        .int_id        (int_id),
        .pending       (pending),
        .overrun       (overrun),
        .in_handler    (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; irq_in = '0; irq_en = '0; mie = 1'b0; mstatus = 1'b0;
        instr_boundary = 1'b0; mret = 1'b1; ovr_clr = '0;
        tick(); tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun got=%b exp=0000", overrun); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL reset_int_id got=%0d exp=0", int_id); end
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL reset_in_handler got=%b exp=0", in_handler); end
        checks++; if (int_ret !== 1'b0) begin errors++; $display("FAIL reset_int_ret got=%b exp=0", int_ret); end
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL reset_int_taken got=%b exp=0", int_taken); end
        mret = 1'b0;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_basic_take();
        mie = 1'b1; mstatus = 1'b1; irq_en = 4'hF; instr_boundary = 1'b1;
        irq_in = 4'b0100;
        tick(); tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL basic_pending_edge2 got=%b exp=0000", pending); end
        tick();
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL basic_pending_edge3 got=%b exp=0100", pending); end
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL basic_taken got=%b exp=1", int_taken); end
        tick();
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL basic_taken_one_cycle got=%b exp=0", int_taken); end
        checks++; if (int_id !== 2'd2) begin errors++; $display("FAIL basic_int_id got=%0d exp=2", int_id); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL basic_pending_cleared got=%b exp=0000", pending); end
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL basic_in_handler got=%b exp=1", in_handler); end
        irq_in = 4'b0000;
        mret = 1'b1;
        #1;
        checks++; if (int_ret !== 1'b1) begin errors++; $display("FAIL basic_ret got=%b exp=1", int_ret); end
        tick();
        mret = 1'b0;
        #1;
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL basic_back_to_idle got=%b exp=0", in_handler); end
        checks++; if (int_ret !== 1'b0) begin errors++; $display("FAIL basic_ret_one_cycle got=%b exp=0", int_ret); end
        tick(); tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_priority();
        instr_boundary = 1'b0; irq_en = 4'b1000;
        irq_in = 4'b1010;
        tick(); tick(); tick();
        checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending got=%b exp=1010", pending); end
        instr_boundary = 1'b1;
        #1;
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL prio_taken_masked got=%b exp=1", int_taken); end
        tick();
        checks++; if (int_id !== 2'd3) begin errors++; $display("FAIL prio_int_id_masked got=%0d exp=3", int_id); end
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL prio_pending_after got=%b exp=0010", pending); end
        // mret together with a boundary in HANDLER: return only, no take.
        irq_en = 4'hF; mret = 1'b1;
        #1;
        checks++; if (int_ret !== 1'b1) begin errors++; $display("FAIL prio_ret got=%b exp=1", int_ret); end
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL prio_no_take_on_ret got=%b exp=0", int_taken); end
        tick();
        mret = 1'b0;
        #1;
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL prio_take_next_boundary got=%b exp=1", int_taken); end
        tick();
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL prio_int_id_unmasked got=%0d exp=1", int_id); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL prio_pending_empty got=%b exp=0000", pending); end
        irq_in = 4'b0000; instr_boundary = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_gating();
        irq_in = 4'b0001;
        tick(); tick(); tick();
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gate_pending got=%b exp=0001", pending); end
        mstatus = 1'b0; mie = 1'b1; instr_boundary = 1'b1;
        #1;
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL gate_mstatus got=%b exp=0", int_taken); end
        tick();
        mstatus = 1'b1; mie = 1'b0;
        #1;
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL gate_mie got=%b exp=0", int_taken); end
        tick();
        mie = 1'b1; instr_boundary = 1'b0;
        #1;
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL gate_boundary got=%b exp=0", int_taken); end
        tick();
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL gate_still_idle got=%b exp=0", in_handler); end
        // All qualifiers up but mret present in IDLE: return passes, take held off.
        instr_boundary = 1'b1; mret = 1'b1;
        #1;
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL gate_mret_suppresses got=%b exp=0", int_taken); end
        checks++; if (int_ret !== 1'b1) begin errors++; $display("FAIL gate_mret_passthrough got=%b exp=1", int_ret); end
        tick();
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL gate_mret_idle got=%b exp=0", in_handler); end
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gate_pending_kept got=%b exp=0001", pending); end
        mret = 1'b0;
        #1;
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL gate_all_enabled got=%b exp=1", int_taken); end
        tick();
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL gate_int_id got=%0d exp=0", int_id); end
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL gate_in_handler got=%b exp=1", in_handler); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_no_nesting();
        irq_in = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL nest_taken_low%0d got=%b exp=0", i, int_taken); end
        end
        irq_in = 4'b0001;
        tick(); tick(); tick();
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL nest_pending got=%b exp=0001", pending); end
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL nest_no_take got=%b exp=0", int_taken); end
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL nest_still_handler got=%b exp=1", in_handler); end
        mret = 1'b1;
        #1;
        checks++; if (int_ret !== 1'b1) begin errors++; $display("FAIL nest_ret got=%b exp=1", int_ret); end
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL nest_ret_no_take got=%b exp=0", int_taken); end
        tick();
        mret = 1'b0;
        #1;
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL nest_idle got=%b exp=0", in_handler); end
        checks++; if (int_ret !== 1'b0) begin errors++; $display("FAIL nest_ret_one_cycle got=%b exp=0", int_ret); end
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL nest_take_after_ret got=%b exp=1", int_taken); end
        tick();
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL nest_reentered got=%b exp=1", in_handler); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL nest_pending_cleared got=%b exp=0000", pending); end
        irq_in = 4'b0000; instr_boundary = 1'b0; mret = 1'b1;
        tick();
        mret = 1'b0;
        tick(); tick();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_overrun();
        irq_in = 4'b0010;
        tick(); tick(); tick();
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_first_pending got=%b exp=0010", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_none_yet got=%b exp=0000", overrun); end
        irq_in = 4'b0000;
        tick(); tick();
        irq_in = 4'b0010;
        tick(); tick(); tick();
        checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_set got=%b exp=0010", overrun); end
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_pending_kept got=%b exp=0010", pending); end
        ovr_clr = 4'b0010;
        tick();
        ovr_clr = 4'b0000;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clr got=%b exp=0000", overrun); end
        // New rise lands in the same cycle that source 1 is taken.
        irq_in = 4'b0000;
        tick(); tick(); tick();
        irq_in = 4'b0010;
        tick(); tick();
        instr_boundary = 1'b1;
        #1;
        checks++; if (int_taken !== 1'b1) begin errors++; $display("FAIL setclr_taken got=%b exp=1", int_taken); end
        tick();
        instr_boundary = 1'b0;
        checks++; if (int_id !== 2'd1) begin errors++; $display("FAIL setclr_int_id got=%0d exp=1", int_id); end
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL setclr_set_wins got=%b exp=0010", pending); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL setclr_no_overrun got=%b exp=0000", overrun); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset_mid_handler();
        checks++; if (in_handler !== 1'b1) begin errors++; $display("FAIL rsth_precondition got=%b exp=1", in_handler); end
        rst_n = 1'b0; irq_in = 4'b0001; mret = 1'b1; instr_boundary = 1'b1;
        #1;
        checks++; if (int_ret !== 1'b0) begin errors++; $display("FAIL rsth_ret_gated got=%b exp=0", int_ret); end
        tick(); tick();
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL rsth_in_handler got=%b exp=0", in_handler); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rsth_pending got=%b exp=0000", pending); end
        checks++; if (int_id !== 2'd0) begin errors++; $display("FAIL rsth_int_id got=%0d exp=0", int_id); end
        checks++; if (int_taken !== 1'b0) begin errors++; $display("FAIL rsth_taken got=%b exp=0", int_taken); end
        rst_n = 1'b1; mret = 1'b0; instr_boundary = 1'b0;
        tick(); tick();
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL rsth_pending_edge2 got=%b exp=0000", pending); end
        tick();
        checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL rsth_pending_edge3 got=%b exp=0001", pending); end
        checks++; if (in_handler !== 1'b0) begin errors++; $display("FAIL rsth_idle got=%b exp=0", in_handler); end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_basic_take();
        test_priority();
        test_gating();
        test_no_nesting();
        test_overrun();
        test_reset_mid_handler();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_otter_int_ctrl
